dz_scan_buf: RTL

Parametrised, double-buffered dot-matrix scan driver for red/green LED matrices; the generalised successor of the fixed 8x8 digit display.
- Upstream logic writes any pattern into a back frame buffer one row at a time, then requests a swap.
- The block applies the swap only at a frame boundary, so the display never tears.
- Scanning supports a configurable matrix size, a per-row dwell time and an anti-ghosting blank interval. It sits between game logic and the matrix pins.

---
 rtl/dz_scan_buf.sv | 115 +++++++++++
 1 files changed

// File: rtl/dz_scan_buf.sv
// Double-buffered red/green dot-matrix scan driver with per-row dwell, anti-ghost
// blanking and tear-free front/back swaps taken only at frame boundaries.
module dz_scan_buf #(
    parameter int ROWS           = 8,
    parameter int COLS           = 8,
    parameter int DWELL          = 1,
    parameter int BLANK          = 0,
    parameter bit ROW_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    wr_en,
    input  logic [$clog2(ROWS)-1:0] wr_row,
    input  logic [COLS-1:0]         wr_r,
    input  logic [COLS-1:0]         wr_g,
    input  logic                    swap_req,
    output logic                    swap_ack,
    output logic                    frame_start,
    output logic [ROWS-1:0]         row,
    output logic [COLS-1:0]         colr,
    output logic [COLS-1:0]         colg
);
    localparam int RW     = $clog2(ROWS);
    localparam int PERIOD = BLANK + DWELL;
    localparam int PW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [ROWS-1:0] ROW_IDLE = ROW_ACTIVE_LOW ? '1 : '0;

    // Each bank entry holds {red, green} for one row.
    logic [2*COLS-1:0] bank [2][ROWS];
    logic              front_sel;
    logic              pending;
    logic              scanning;
    logic              ack_pipe;
    logic [RW-1:0]     ri;
    logic [PW-1:0]     pc;

    logic              last_pc;
    logic              last_row;
    logic              boundary;
    logic              do_swap;
    logic              wr_ok;
    logic              show;
    logic [2*COLS-1:0] front_row;
    logic [ROWS-1:0]   row_sel;

    // A disabled or not-yet-started scan counts as a boundary so pending swaps land at once.
    always_comb begin
        last_pc   = (int'(pc) == PERIOD - 1);
        last_row  = (int'(ri) == ROWS - 1);
        boundary  = !enable || !scanning || (last_pc && last_row);
        do_swap   = boundary && (pending || swap_req);
        wr_ok     = wr_en && (int'(wr_row) < ROWS);
        show      = scanning && (int'(pc) >= BLANK);
        front_row = bank[front_sel][ri];
        row_sel   = ROWS'(1) << ri;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scanning  <= 1'b0;
            ri        <= '0;
            pc        <= '0;
            pending   <= 1'b0;
            front_sel <= 1'b0;
            ack_pipe  <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                bank[0][r] <= '0;
                bank[1][r] <= '0;
            end
        end else begin
            // Writes use the pre-swap back bank, so a boundary-cycle write shows in the new frame.
            if (wr_ok) begin
                bank[~front_sel][wr_row] <= {wr_r, wr_g};
            end

            if (!enable) begin
                scanning <= 1'b0;
                ri       <= '0;
                pc       <= '0;
            end else if (!scanning || last_pc) begin
                scanning <= 1'b1;
                pc       <= '0;
                ri       <= (!scanning || last_row) ? '0 : ri + 1'b1;
            end else begin
                pc <= pc + 1'b1;
            end

            if (do_swap) begin
                front_sel <= ~front_sel;
                pending   <= 1'b0;
            end else begin
                pending <= pending | swap_req;
            end
            ack_pipe <= do_swap;
        end
    end

    // Output stage lags the scan state by one cycle; ack is delayed to line up with frame_start.
    always_ff @(posedge clk) begin
        if (rst) begin
            row         <= ROW_IDLE;
            colr        <= '0;
            colg        <= '0;
            swap_ack    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            swap_ack    <= ack_pipe;
            frame_start <= scanning && (ri == '0) && (pc == '0);
            row         <= show ? (ROW_ACTIVE_LOW ? ~row_sel : row_sel) : ROW_IDLE;
            colr        <= show ? front_row[2*COLS-1:COLS] : '0;
            colg        <= show ? front_row[COLS-1:0] : '0;
        end
    end
endmodule
